// File: rtl/gpi_debounce.sv
// Memory-mapped general-purpose input block: per-pin 2-flop synchronizer and
// debounce filter, programmable edge detection into a sticky W1C pending register.

module gpi_debounce_bit #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_stable
);

  localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchronizer chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

module gpi_debounce #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpi,
  output logic             irq
);

  localparam logic [1:0] OFF_IDR  = 2'd0;
  localparam logic [1:0] OFF_IER  = 2'd1;
  localparam logic [1:0] OFF_ISR  = 2'd2;
  localparam logic [1:0] OFF_EDGE = 2'd3;

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_ier;
  logic [WIDTH-1:0] r_isr;
  logic [WIDTH-1:0] r_edge;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_wdata;
  logic [1:0]       w_off;
  logic             w_wr;
  logic             w_unused;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    gpi_debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_pin   (gpi[g]),
      .o_stable(w_stable[g])
    );
  end

  assign w_off    = addr[3:2];
  assign w_wr     = cs & wr;
  assign w_wdata  = wdata[WIDTH-1:0];
  assign w_unused = &{1'b0, addr, wdata};

  assign w_rise = w_stable & ~r_prev;
  assign w_fall = ~w_stable & r_prev;
  assign w_ev   = (r_edge & w_rise) | (~r_edge & w_fall);
  assign w_w1c  = (w_wr && (w_off == OFF_ISR)) ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_ier  <= '0;
      r_isr  <= '0;
      r_edge <= '0;
    end else begin
      r_prev <= w_stable;
      // A new event outranks a same-cycle clear so no edge is ever lost.
      r_isr  <= (r_isr & ~w_w1c) | w_ev;
      if (w_wr && (w_off == OFF_IER))  r_ier  <= w_wdata;
      if (w_wr && (w_off == OFF_EDGE)) r_edge <= w_wdata;
    end
  end

  assign irq = |(r_isr & r_ier);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = 32'h0;
    if (cs) begin
      case (w_off)
        OFF_IDR:  rdata = 32'(w_stable);
        OFF_IER:  rdata = 32'(r_ier);
        OFF_ISR:  rdata = 32'(r_isr);
        OFF_EDGE: rdata = 32'(r_edge);
        default:  rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed self-checking bench for gpi_debounce with default parameters
// (WIDTH=8, DB_CYCLES=4).

module tb_gpi_debounce;

  localparam logic [1:0] IDR  = 2'd0;
  localparam logic [1:0] IER  = 2'd1;
  localparam logic [1:0] ISR  = 2'd2;
  localparam logic [1:0] EDGE = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  gpi;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  gpi_debounce #(.WIDTH(8), .DB_CYCLES(4)) dut (
    .clk  (clk),
    .reset(reset),
    .cs   (cs),
    .wr   (wr),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .gpi  (gpi),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
    cs    = 1'b1;
    wr    = 1'b1;
    addr  = {28'h4000_010, off, 2'b00};
    wdata = d;
    @(posedge clk);
    #1;
    cs    = 1'b0;
    wr    = 1'b0;
    wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    cs   = 1'b1;
    wr   = 1'b0;
    addr = {28'h4000_010, off, 2'b00};
    #1;
    d  = rdata;
    cs = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gpi   = 8'h00;
    cs    = 1'b0;
    wr    = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    gpi   = 8'hFF;
    cs    = 1'b0;
    wr    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    tick(2);
    for (int r = 0; r < 4; r++) begin
      bus_read(2'(r), d);
      n_checks++;
      if (d !== 32'h0) begin
        $display("FAIL reset_reg%0d: got %h expected %h", r, d, 32'h0);
        n_fail++;
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      $display("FAIL reset_irq: got %b expected 0", irq);
      n_fail++;
    end
    reset = 1'b0;
    tick(5);
    bus_read(IDR, d);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL reset_idr_edge5: got %h expected %h", d, 32'h0);
      n_fail++;
    end
    tick(1);
    bus_read(IDR, d);
    n_checks++;
    if (d !== 32'hFF) begin
      $display("FAIL reset_idr_edge6: got %h expected %h", d, 32'hFF);
      n_fail++;
    end
    tick(3);
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL reset_isr_after: got %h expected %h", d, 32'h0);
      n_fail++;
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    do_reset();
    gpi = 8'h01;
    tick(3);
    gpi = 8'h00;
    tick(10);
    bus_read(IDR, d);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL glitch3_idr: got %h expected %h", d, 32'h0);
      n_fail++;
    end
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL glitch3_isr: got %h expected %h", d, 32'h0);
      n_fail++;
    end
    gpi = 8'h01;
    tick(4);
    gpi = 8'h00;
    tick(1);
    bus_read(IDR, d);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL pulse4_idr_edge5: got %h expected %h", d, 32'h0);
      n_fail++;
    end
    tick(1);
    bus_read(IDR, d);
    n_checks++;
    if (d !== 32'h01) begin
      $display("FAIL pulse4_idr_edge6: got %h expected %h", d, 32'h01);
      n_fail++;
    end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    do_reset();
    bus_write(EDGE, 32'h01);
    bus_write(IER, 32'h01);
    gpi = 8'h01;
    tick(6);
    bus_read(IDR, d);
    n_checks++;
    if (d !== 32'h01) begin
      $display("FAIL rise_idr_edge6: got %h expected %h", d, 32'h01);
      n_fail++;
    end
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      $display("FAIL rise_isr_edge6: got isr=%h irq=%b expected isr=0 irq=0", d, irq);
      n_fail++;
    end
    tick(1);
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h01 || irq !== 1'b1) begin
      $display("FAIL rise_isr_edge7: got isr=%h irq=%b expected isr=01 irq=1", d, irq);
      n_fail++;
    end
    bus_write(ISR, 32'h01);
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      $display("FAIL rise_w1c: got isr=%h irq=%b expected isr=0 irq=0", d, irq);
      n_fail++;
    end
    tick(3);
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL rise_no_reset: got %h expected %h", d, 32'h0);
      n_fail++;
    end
  endtask

  task automatic test_fall_mask();
    logic [31:0] d;
    do_reset();
    gpi = 8'h08;
    tick(10);
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL fall_rise_ignored: got %h expected %h", d, 32'h0);
      n_fail++;
    end
    gpi = 8'h00;
    tick(7);
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h08 || irq !== 1'b0) begin
      $display("FAIL fall_isr_masked: got isr=%h irq=%b expected isr=08 irq=0", d, irq);
      n_fail++;
    end
    bus_write(IER, 32'h08);
    n_checks++;
    if (irq !== 1'b1) begin
      $display("FAIL fall_ier_unmask: got irq=%b expected 1", irq);
      n_fail++;
    end
    bus_write(EDGE, 32'h08);
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h08) begin
      $display("FAIL fall_edge_write_keeps_isr: got %h expected %h", d, 32'h08);
      n_fail++;
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    do_reset();
    bus_write(EDGE, 32'h01);
    gpi = 8'h01;
    tick(6);
    bus_write(ISR, 32'h01);
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h01) begin
      $display("FAIL collision_set_wins: got %h expected %h", d, 32'h01);
      n_fail++;
    end
    bus_write(ISR, 32'h01);
    bus_read(ISR, d);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL collision_later_clear: got %h expected %h", d, 32'h0);
      n_fail++;
    end
  endtask

  task automatic test_bus_decode();
    logic [31:0] d;
    do_reset();
    gpi = 8'h5A;
    tick(8);
    bus_write(IDR, 32'hFFFF_FFFF);
    bus_read(IDR, d);
    n_checks++;
    if (d !== 32'h5A) begin
      $display("FAIL idr_read_only: got %h expected %h", d, 32'h5A);
      n_fail++;
    end
    bus_write(IER, 32'h1234_56AB);
    bus_read(IER, d);
    n_checks++;
    if (d !== 32'h0000_00AB) begin
      $display("FAIL ier_width_mask: got %h expected %h", d, 32'h0000_00AB);
      n_fail++;
    end
    cs   = 1'b0;
    addr = 32'h4000_0104;
    #1;
    n_checks++;
    if (rdata !== 32'h0) begin
      $display("FAIL read_cs_low: got %h expected %h", rdata, 32'h0);
      n_fail++;
    end
    cs    = 1'b0;
    wr    = 1'b1;
    addr  = 32'h4000_0104;
    wdata = 32'h0;
    tick(1);
    wr = 1'b0;
    cs   = 1'b1;
    addr = 32'hFFFF_FF04;
    #1;
    n_checks++;
    if (rdata !== 32'h0000_00AB) begin
      $display("FAIL write_cs_low_ignored: got %h expected %h", rdata, 32'h0000_00AB);
      n_fail++;
    end
    cs = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_rise_irq();
    test_fall_mask();
    test_collision();
    test_bus_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Memory-mapped general-purpose input responder for the MCU data bus; the input-direction counterpart of the GPO block.
- Decoded at 0x4000_01xx; the address decoder drives cs.
- Each pin passes through a 2-flop synchronizer and a per-bit debounce filter.
- Flags programmable rising/falling edges in a sticky pending register and drives one level-sensitive irq.

Parameters:
- WIDTH, 8, number of input pins (1..32); register bits above WIDTH read 0.
- DB_CYCLES, 4, consecutive cycles a synchronized input must differ from the filtered value before it is accepted (>=1).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- cs, input, 1, chip select from the address decoder.
- wr, input, 1, write strobe (core DWe); a write occurs when cs&&wr at a clk edge.
- addr, input, 32, bus address; only addr[3:2] is decoded, other bits ignored.
- wdata, input, 32, write data.
- rdata, output, 32, read data; combinational, valid in the same cycle as cs.
- gpi, input, WIDTH, asynchronous external pins.
- irq, output, 1, level interrupt = |(ISR & IER).

Behaviour:
- Register map (word offsets): 0x0 IDR RO filtered input value; 0x4 IER RW interrupt enable; 0x8 ISR pending, read / write-1-to-clear; 0xC EDGE RW, bit=1 rising, bit=0 falling.
- Reads: rdata = selected register zero-extended when cs=1, else 32'h0; no wait states, zero-latency mux.
- Writes: IER/EDGE take wdata[WIDTH-1:0]; writes to IDR are ignored; ISR clears bits where wdata=1. All accesses are full word and byte enables are not used.
- Reset (sync, any time, including mid-debounce): sync flops, filtered value, previous-filtered, counters, IER, ISR and EDGE all 0; irq=0. rdata depends only on registers and returns 0 for all registers after reset.
- Synchronizer: s1<=gpi; s2<=s1.
- Debounce, per bit, with counter width clog2(DB_CYCLES+1):
  - If s2==stable: cnt<=0.
  - Else if cnt==DB_CYCLES-1: stable<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
  - A glitch shorter than DB_CYCLES cycles at s2 never reaches IDR.
- Latency: gpi changes before edge 1; s2 reflects it at edge 2; IDR updates at edge 2+DB_CYCLES (6 with defaults).
- Edge detect: prev<=stable each cycle. rise=stable&~prev; fall=~stable&prev. ev = EDGE ? rise : fall.
  - ISR bit sets at the edge after IDR changes (edge 3+DB_CYCLES).
  - ISR is sticky until cleared.
- ISR sets regardless of IER; IER gates only irq. irq is combinational from the ISR/IER flops, so it asserts in the same cycle ISR sets.
- Simultaneous ISR set event and W1C on the same bit in the same cycle: set wins, and the bit stays 1.
- Writing EDGE or IER never creates or clears pending bits itself.
- Unused offsets: none (4 registers fill addr[3:2]).
- Writes with cs=0 are ignored.

Test Plan:
- Reset: hold reset 2 cycles with gpi=8'hFF -> all reads 0, irq=0. Release -> IDR reads 8'hFF at edge 2+4=6 after release; ISR stays 0 while EDGE=0 and no falling edge occurs.
- Debounce: gpi[0] pulse of 3 cycles -> IDR stays 0, ISR=0. Pulse of 4 cycles -> IDR[0]=1 exactly 6 edges after the rise.
- Rising IRQ: EDGE=8'h01, IER=8'h01, gpi[0] 0->1 held -> ISR=8'h01 and irq=1 on edge 7. Write ISR=8'h01 -> ISR=0, irq=0 next cycle.
- Falling and mask: EDGE=0, IER=0, gpi[3] 1->0 -> ISR=8'h08 and irq stays 0. Write IER=8'h08 -> irq=1 immediately after the write edge.
- Set/clear collision: issue W1C of bit 0 on the same edge the bit-0 event sets -> ISR[0] reads 1 afterward.
- Bus decode: write IDR with 32'hFFFF_FFFF -> IDR unchanged. Read with cs=0 -> rdata=0. WIDTH=8 -> IER readback masks wdata 32'h1234_56AB to 32'h0000_00AB.
